// File: rtl/boot_loader.sv
// Streams a program image into ram256x8 over the MOV/RW/MOC handshake and holds
// the CPU in reset (cpu_clr low) until the whole image has been written.
module boot_loader #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int START_ADDR  = 0,
  parameter int MOC_TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              start,
  input  logic [7:0]        data_in,
  input  logic              data_valid,
  input  logic              data_last,
  output logic              data_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              MOV,
  output logic              RW,
  output logic [1:0]        typeData,
  input  logic              MOC,
  output logic              cpu_clr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   byte_count,
  output logic [2:0]        dbg_state
);

  // Stream side: data_valid/data_in/data_last are consumed on the rising edge
  // where data_valid = 1 and data_ready = 1; data_ready is a registered decode
  // of WAIT_BYTE, so it never depends combinationally on data_valid.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_BYTE = 3'd1,
    S_WRITE     = 3'd2,
    S_WAIT_MOC  = 3'd3,
    S_DONE      = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  localparam int TO_W = (MOC_TIMEOUT > 1) ? $clog2(MOC_TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] ADDR_START = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_FULL   = (ADDR_W+1)'(DEPTH);
  localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(MOC_TIMEOUT - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_mov;
  logic                r_rw;
  logic                r_ready;
  logic                r_cpu_clr;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic                r_last;
  logic [ADDR_W:0]     r_byte_count;
  logic [TO_W-1:0]     r_to_cnt;

  logic [ADDR_W:0]     w_count_inc;
  logic [ADDR_W-1:0]   w_addr_inc;

  assign w_count_inc = r_byte_count + (ADDR_W+1)'(1);
  assign w_addr_inc  = (r_addr == ADDR_LAST) ? '0 : r_addr + ADDR_W'(1);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state      <= S_IDLE;
      r_addr       <= ADDR_START;
      r_wdata      <= '0;
      r_mov        <= 1'b0;
      r_rw         <= 1'b1;
      r_ready      <= 1'b0;
      r_cpu_clr    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_last       <= 1'b0;
      r_byte_count <= '0;
      r_to_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state      <= S_WAIT_BYTE;
            r_addr       <= ADDR_START;
            r_byte_count <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_busy       <= 1'b1;
            r_cpu_clr    <= 1'b0;
            r_ready      <= 1'b1;
          end
        end
        S_WAIT_BYTE: begin
          if (data_valid) begin
            r_wdata <= {data_in, 24'h000000};
            r_last  <= data_last;
            r_ready <= 1'b0;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_mov    <= 1'b1;
          r_rw     <= 1'b0;
          r_to_cnt <= '0;
          r_state  <= S_WAIT_MOC;
        end
        S_WAIT_MOC: begin
          if (MOC) begin
            r_mov        <= 1'b0;
            r_rw         <= 1'b1;
            r_byte_count <= w_count_inc;
            r_addr       <= w_addr_inc;
            if (r_last) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_cpu_clr <= 1'b1;
            end else if (w_count_inc == CNT_FULL) begin
              // Image would wrap onto START_ADDR: stop rather than overwrite.
              r_state <= S_ERROR;
              r_error <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_WAIT_BYTE;
              r_ready <= 1'b1;
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_mov   <= 1'b0;
            r_rw    <= 1'b1;
            r_state <= S_ERROR;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_ready = r_ready;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign MOV        = r_mov;
  assign RW         = r_rw;
  assign typeData   = 2'b00;
  assign cpu_clr    = r_cpu_clr;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign byte_count = r_byte_count;
  assign dbg_state  = r_state;

endmodule
